// File: rtl/mult_seq.sv
// Iterative 32x32 shift-add multiplier (MULT/MULTU into HI/LO) sharing a single fa_32 adder.
// Define MULT_SIGNED_EN to compile in signed MULT support (abs/negate states, 37-cycle latency).

module fa_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic w_c;

  always_comb begin
    w_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < 32; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

module mult_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_is_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
`ifdef MULT_SIGNED_EN
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
`endif
    S_RUN    = 3'd3,
    S_DONE   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_mcand;
  logic [31:0] r_acc;
  logic [31:0] r_mplr;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_addA;
  logic [31:0] w_addB;
  logic        w_cin;
  logic [31:0] w_sum;
  logic        w_cout;

`ifdef MULT_SIGNED_EN
  logic r_sgn;
  logic r_neg;
  logic r_csave;
  logic w_absA;
  logic w_absB;

  // ABS states run before mcand/mplr change, so bit 31 still holds the operand sign.
  assign w_absA = r_sgn & r_mcand[31];
  assign w_absB = r_sgn & r_mplr[31];
`endif

  fa_32 u_fa (
    .i_a   (w_addA),
    .i_b   (w_addB),
    .i_cin (w_cin),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_comb begin
    w_addA = r_acc;
    w_addB = '0;
    w_cin  = 1'b0;
    case (r_state)
`ifdef MULT_SIGNED_EN
      S_ABS_A: begin
        w_addA = w_absA ? ~r_mcand : r_mcand;
        w_cin  = w_absA;
      end
      S_ABS_B: begin
        w_addA = w_absB ? ~r_mplr : r_mplr;
        w_cin  = w_absB;
      end
      S_NEG_LO: begin
        w_addA = r_neg ? ~r_mplr : r_mplr;
        w_cin  = r_neg;
      end
      S_NEG_HI: begin
        w_addA = r_neg ? ~r_acc : r_acc;
        w_cin  = r_neg & r_csave;
      end
`endif
      S_RUN: begin
        w_addA = r_acc;
        w_addB = r_mplr[0] ? r_mcand : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
`ifdef MULT_SIGNED_EN
          w_nextState = S_ABS_A;
`else
          w_nextState = S_RUN;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      S_ABS_A:  w_nextState = S_ABS_B;
      S_ABS_B:  w_nextState = S_RUN;
      S_NEG_LO: w_nextState = S_NEG_HI;
      S_NEG_HI: w_nextState = S_DONE;
`endif
      S_RUN: begin
        if (r_cnt == 5'd31) begin
`ifdef MULT_SIGNED_EN
          w_nextState = S_NEG_LO;
`else
          w_nextState = S_DONE;
`endif
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The product is assembled in place: acc is HI, mplr is LO and shifts right each RUN cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULT_SIGNED_EN
      r_sgn   <= 1'b0;
      r_neg   <= 1'b0;
      r_csave <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mcand <= i_a;
            r_mplr  <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
`ifdef MULT_SIGNED_EN
            r_sgn   <= i_is_signed;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        S_ABS_A: begin
          r_mcand <= w_sum;
          r_neg   <= r_sgn & (r_mcand[31] ^ r_mplr[31]);
        end
        S_ABS_B: r_mplr <= w_sum;
        S_NEG_LO: begin
          r_mplr  <= w_sum;
          r_csave <= r_neg & w_cout;
        end
        S_NEG_HI: r_acc <= w_sum;
`endif
        S_RUN: begin
          r_acc  <= {w_cout, w_sum[31:1]};
          r_mplr <= {w_sum[0], r_mplr[31:1]};
          r_cnt  <= r_cnt + 5'd1;
        end
        S_DONE: begin
          r_hi <= r_acc;
          r_lo <= r_mplr;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);
  assign o_hi   = o_done ? r_acc  : r_hi;
  assign o_lo   = o_done ? r_mplr : r_lo;

endmodule
